uart_arb_ctrl: RTL and testbench
================================

Name: uart_arb_ctrl

Overview:
- Bus-master controller that owns the slave port of the existing UART peripheral (register map: 0 = ctrl {baud_div[31:16], rx_en[1], tx_en[0]}; 1 = status {rx_empty, rx_full, tx_empty, tx_full}; 2 = RX data with pop; 3 = TX push).
- Initialises baud/enables after reset, polls status, drains RX into a one-entry output register, and round-robin arbitrates NUM_REQ byte-stream requesters onto the TX FIFO.
- Accepts runtime baud reconfiguration, applied only when TX is drained.
- Sits between core-side console/debug sources and the UART instance.

Parameters:
- NUM_REQ, 2, number of TX requesters (1..8).
- BAUD_DIV_INIT, 16'd868, baud divisor written at init.
- XLEN, 32, UART data bus width (from ceres_param).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester byte valid
- req_data_i  in  NUM_REQ*8  per-requester byte; requester r uses bits [8r+7:8r]
- req_ready_o  out  NUM_REQ  one-cycle accept pulse to the granted requester
- rx_valid_o  out  1  received byte available
- rx_data_o  out  8  received byte
- rx_ready_i  in  1  consumer takes the byte
- cfg_we_i  in  1  baud change request (pulse)
- cfg_baud_i  in  16  new divisor, sampled with cfg_we_i
- cfg_busy_o  out  1  baud change pending or in progress
- init_done_o  out  1  first ctrl write completed
- uart_stb_o  out  1  UART strobe
- uart_adr_o  out  2  UART register address
- uart_byte_sel_o  out  4  UART byte select
- uart_we_o  out  1  UART write enable
- uart_dat_o  out  XLEN  UART write data
- uart_dat_i  in  XLEN  UART read data (combinational from UART)

Behaviour:
- Reset (async assert, sync release): state=INIT; all uart_* outputs 0; req_ready_o=0; rx_valid_o=0; rx_data_o=0; cfg_busy_o=0; init_done_o=0; rr_ptr=0; baud_q=BAUD_DIV_INIT.
- Every UART access lasts exactly one cycle with uart_stb_o=1. uart_stb_o=0 in all other states.
- A stb on adr 2 pops the RX FIFO, so adr 2 is driven only in RX_RD.
- Idle bus values: adr=0, we=0, byte_sel=0.
- INIT: write adr 0, byte_sel 4'b1111, dat={baud_q,14'b0,rx_en,1'b1} -> POLL. init_done_o rises the cycle after and stays 1 until reset.
- POLL: read adr 1, byte_sel 0, we=0; register st={rx_empty,rx_full,tx_empty,tx_full}=uart_dat_i[3:0] -> DECIDE.
- DECIDE (no bus access) picks the next state by priority:
  - CFG if cfg pending and st.tx_empty=1.
  - Else RX_RD if st.rx_empty=0 and rx_valid_o=0.
  - Else TX_WR if any req_valid_i and st.tx_full=0.
  - Else POLL.
- CFG: write adr 0, byte_sel 4'b1111, new baud_q; clear pending -> POLL. cfg_busy_o falls the cycle after.
- RX_RD: read adr 2, byte_sel 4'b0001; rx_data_o<=uart_dat_i[7:0]; rx_valid_o<=1 -> POLL.
- TX_WR: write adr 3, byte_sel 4'b0001, we=1, dat={24'b0, req_data[g]}; req_ready_o[g]=1 this cycle only; rr_ptr<=g+1 mod NUM_REQ -> POLL.
- Grant g = first valid requester at or after rr_ptr, wrapping. Computed in DECIDE and registered.
- Requester rules: must hold valid and data stable until ready. Dropping valid before grant is allowed; dropping it after grant is a protocol violation.
- rx_valid_o clears on the cycle after rx_valid_o&&rx_ready_i. A clear in the same cycle as a DECIDE is seen by the next DECIDE only; no bypass.
- cfg_we_i sets pending and cfg_busy_o=1 and captures cfg_baud_i. A second cfg_we_i while pending overwrites the captured value. A cfg_we_i during INIT is held until after INIT.
- Throughput: one byte per 3 cycles (POLL, DECIDE, access).
- Reset mid-operation: immediate return to reset values; UART state is re-initialised by INIT.

Optional Feature:
- Macro UART_ARB_CTRL_RX_EN.
- Defined: RX path as above; rx_en written as 1.
- Undefined: RX_RD state removed; rx_en written as 0; rx_valid_o=0 and rx_data_o=0 constantly; rx_ready_i ignored.

Test Plan:
- Reset release -> first stb cycle has adr=0, we=1, byte_sel=4'b1111, dat=32'h0364_0003; init_done_o=1 the next cycle.
- req_valid_i=2'b11, data 8'h41/8'h42 held, UART never full -> TX pushes alternate 41,42,41,... Each req_ready_o pulse is 1 cycle, with the pushes 3 cycles apart.
- tx_full=1 reported in status with req pending -> no adr-3 write; the write occurs in the first DECIDE after tx_full=0.
- Inject RX byte 8'h5A with rx_ready_i=0 -> rx_valid_o=1, rx_data_o=8'h5A. A second RX byte is not popped: no adr-2 stb until rx_ready_i.
- cfg_we_i with cfg_baud_i=16'd434 while TX FIFO non-empty -> cfg_busy_o=1. No adr-0 write until status tx_empty=1; then the write has dat=32'h01B2_0003 and cfg_busy_o falls.
- Assert rst_ni low mid-TX_WR -> all outputs 0 asynchronously; INIT sequence repeats after release.

Source files
------------

// File: rtl/uart_arb_ctrl.sv
// rtl/uart_arb_ctrl.sv - UART slave-port master: init, status poll, RX drain, round-robin TX arbitration, baud reconfig.
// Optional RX path enabled by defining UART_ARB_CTRL_RX_EN.
module uart_arb_ctrl #(
    parameter int          NUM_REQ       = 2,
    parameter logic [15:0] BAUD_DIV_INIT = 16'd868,
    parameter int          XLEN          = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 rx_valid_o,
    output logic [7:0]           rx_data_o,
    input  logic                 rx_ready_i,
    input  logic                 cfg_we_i,
    input  logic [15:0]          cfg_baud_i,
    output logic                 cfg_busy_o,
    output logic                 init_done_o,
    output logic                 uart_stb_o,
    output logic [1:0]           uart_adr_o,
    output logic [3:0]           uart_byte_sel_o,
    output logic                 uart_we_o,
    output logic [XLEN-1:0]      uart_dat_o,
    input  logic [XLEN-1:0]      uart_dat_i
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef UART_ARB_CTRL_RX_EN
    localparam logic RX_EN = 1'b1;
    typedef enum logic [2:0] {INIT, POLL, DECIDE, CFG, RX_RD, TX_WR} state_t;
`else
    localparam logic RX_EN = 1'b0;
    typedef enum logic [2:0] {INIT, POLL, DECIDE, CFG, TX_WR} state_t;
`endif

    state_t        state_q, state_d;
    logic          started_q;
    logic [3:0]    st_q;
    logic [PW-1:0] rr_ptr_q, grant_q, gnt_d;
    logic [15:0]   baud_q, cfg_baud_q;
    logic          cfg_pend_q, init_done_q;
    logic          rx_valid_q;
    logic [7:0]    rx_data_q;
    logic [7:0]    tx_byte;
    logic          found;
    int            idx;

    function automatic logic [XLEN-1:0] ctrl_word(input logic [15:0] baud);
        ctrl_word = XLEN'({baud, 14'b0, RX_EN, 1'b1});
    endfunction

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_d = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                gnt_d = PW'(idx);
            end
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (PW'(k) == grant_q) tx_byte = req_data_i[8*k +: 8];
        end
    end

    always_comb begin
        state_d         = state_q;
        uart_stb_o      = 1'b0;
        uart_adr_o      = 2'd0;
        uart_we_o       = 1'b0;
        uart_byte_sel_o = 4'b0000;
        uart_dat_o      = '0;
        req_ready_o     = '0;
        case (state_q)
            INIT: begin
                // started_q keeps the bus quiet for the first cycle out of reset
                if (started_q) begin
                    uart_stb_o      = 1'b1;
                    uart_we_o       = 1'b1;
                    uart_byte_sel_o = 4'b1111;
                    uart_dat_o      = ctrl_word(baud_q);
                    state_d         = POLL;
                end
            end
            POLL: begin
                uart_stb_o = 1'b1;
                uart_adr_o = 2'd1;
                state_d    = DECIDE;
            end
            DECIDE: begin
                if (cfg_pend_q && st_q[1])
                    state_d = CFG;
`ifdef UART_ARB_CTRL_RX_EN
                else if (!st_q[3] && !rx_valid_q)
                    state_d = RX_RD;
`endif
                else if (|req_valid_i && !st_q[0])
                    state_d = TX_WR;
                else
                    state_d = POLL;
            end
            CFG: begin
                uart_stb_o      = 1'b1;
                uart_we_o       = 1'b1;
                uart_byte_sel_o = 4'b1111;
                uart_dat_o      = ctrl_word(cfg_baud_q);
                state_d         = POLL;
            end
`ifdef UART_ARB_CTRL_RX_EN
            RX_RD: begin
                uart_stb_o      = 1'b1;
                uart_adr_o      = 2'd2;
                uart_byte_sel_o = 4'b0001;
                state_d         = POLL;
            end
`endif
            TX_WR: begin
                uart_stb_o      = 1'b1;
                uart_adr_o      = 2'd3;
                uart_we_o       = 1'b1;
                uart_byte_sel_o = 4'b0001;
                uart_dat_o      = XLEN'(tx_byte);
                for (int k = 0; k < NUM_REQ; k++)
                    req_ready_o[k] = (PW'(k) == grant_q);
                state_d         = POLL;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= INIT;
            started_q   <= 1'b0;
            st_q        <= 4'b0000;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            baud_q      <= BAUD_DIV_INIT;
            cfg_baud_q  <= BAUD_DIV_INIT;
            cfg_pend_q  <= 1'b0;
            init_done_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            if (state_q == POLL) st_q <= uart_dat_i[3:0];
            if (state_q == DECIDE) grant_q <= gnt_d;
            if (state_q == TX_WR)
                rr_ptr_q <= (grant_q == PW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            if (state_q == INIT && started_q) init_done_q <= 1'b1;
            if (state_q == CFG) begin
                baud_q     <= cfg_baud_q;
                cfg_pend_q <= 1'b0;
            end
            // A request arriving during the CFG write stays pending with its new value
            if (cfg_we_i) begin
                cfg_pend_q <= 1'b1;
                cfg_baud_q <= cfg_baud_i;
            end
`ifdef UART_ARB_CTRL_RX_EN
            if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;
            if (state_q == RX_RD) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= uart_dat_i[7:0];
            end
`endif
        end
    end

`ifdef UART_ARB_CTRL_RX_EN
    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
`else
    assign rx_valid_o = 1'b0;
    assign rx_data_o  = 8'h00;
`endif
    assign cfg_busy_o  = cfg_pend_q;
    assign init_done_o = init_done_q;

    logic unused;
    assign unused = &{1'b0, uart_dat_i, st_q, rx_ready_i, rx_valid_q, rx_data_q};

endmodule

// File: tb/tb_uart_arb_ctrl.sv
// tb/tb_uart_arb_ctrl.sv - Directed table-driven bench for uart_arb_ctrl with a status/RX UART model.
module tb_uart_arb_ctrl;

`ifdef UART_ARB_CTRL_RX_EN
    localparam logic RXB = 1'b1;
`else
    localparam logic RXB = 1'b0;
`endif
    localparam logic [31:0] EXP_INIT = {16'h0364, 14'b0, RXB, 1'b1};
    localparam logic [31:0] EXP_CFG  = {16'h01B2, 14'b0, RXB, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        cfg_we;
    logic [15:0] cfg_baud;
    logic        cfg_busy;
    logic        init_done;
    logic        stb;
    logic [1:0]  adr;
    logic [3:0]  bsel;
    logic        we;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic [3:0]  st;
    logic [7:0]  rx_byte;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign dat_i = (adr == 2'd1) ? {28'b0, st} :
                   (adr == 2'd2) ? {24'b0, rx_byte} : 32'b0;

    uart_arb_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
        .rx_valid_o(rx_valid), .rx_data_o(rx_data), .rx_ready_i(rx_ready),
        .cfg_we_i(cfg_we), .cfg_baud_i(cfg_baud), .cfg_busy_o(cfg_busy),
        .init_done_o(init_done),
        .uart_stb_o(stb), .uart_adr_o(adr), .uart_byte_sel_o(bsel),
        .uart_we_o(we), .uart_dat_o(dat_o), .uart_dat_i(dat_i)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic wait_stb(input logic [1:0] a, input string nm);
        int n = 0;
        while (!(stb && adr == a) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_seen"}, 32'(stb && adr == a), 32'd1);
    endtask

    typedef struct {
        logic [1:0] valid;
        logic [3:0] status;
        logic [1:0] adr;
        logic       we;
        logic [7:0] data;
        logic [1:0] ready;
    } vec_t;

    vec_t vt[10];

    initial begin
        int bad;
        // status = {rx_empty, rx_full, tx_empty, tx_full}; req0=41, req1=42
        vt[0] = '{2'b11, 4'b1010, 2'd3, 1'b1, 8'h41, 2'b01};
        vt[1] = '{2'b11, 4'b1010, 2'd3, 1'b1, 8'h42, 2'b10};
        vt[2] = '{2'b11, 4'b1010, 2'd3, 1'b1, 8'h41, 2'b01};
        vt[3] = '{2'b01, 4'b1010, 2'd3, 1'b1, 8'h41, 2'b01};
        vt[4] = '{2'b10, 4'b1010, 2'd3, 1'b1, 8'h42, 2'b10};
        vt[5] = '{2'b11, 4'b1001, 2'd1, 1'b0, 8'h00, 2'b00};
        vt[6] = '{2'b11, 4'b1000, 2'd3, 1'b1, 8'h41, 2'b01};
        vt[7] = '{2'b00, 4'b1010, 2'd1, 1'b0, 8'h00, 2'b00};
        vt[8] = '{2'b10, 4'b1000, 2'd3, 1'b1, 8'h42, 2'b10};
        vt[9] = '{2'b10, 4'b1010, 2'd3, 1'b1, 8'h42, 2'b10};

        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_data  = {8'h42, 8'h41};
        rx_ready  = 1'b0;
        cfg_we    = 1'b0;
        cfg_baud  = 16'd0;
        st        = 4'b1010;
        rx_byte   = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_stb", 32'(stb), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_cfg_busy", 32'(cfg_busy), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        rst_n = 1'b1;

        wait_stb(2'd0, "init");
        chk("init_we", 32'(we), 1);
        chk("init_bsel", 32'(bsel), 32'hF);
        chk("init_dat", dat_o, EXP_INIT);
        @(negedge clk);
        chk("init_done_after", 32'(init_done), 1);

        for (int i = 0; i < 10; i++) begin
            req_valid = vt[i].valid;
            st        = vt[i].status;
            wait_stb(2'd1, $sformatf("poll%0d", i));
            @(negedge clk);
            chk($sformatf("v%0d_decide_stb", i), 32'(stb), 0);
            chk($sformatf("v%0d_decide_ready", i), 32'(req_ready), 0);
            @(negedge clk);
            chk($sformatf("v%0d_adr", i), 32'(adr), 32'(vt[i].adr));
            chk($sformatf("v%0d_we", i), 32'(we), 32'(vt[i].we));
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vt[i].ready));
            if (vt[i].adr == 2'd3) begin
                chk($sformatf("v%0d_dat", i), dat_o, {24'b0, vt[i].data});
                chk($sformatf("v%0d_bsel", i), 32'(bsel), 32'h1);
            end
        end

        req_valid = 2'b00;
        st        = 4'b1000;
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_baud = 16'd434;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("cfg_busy_set", 32'(cfg_busy), 1);
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (stb && adr == 2'd0) bad++;
        end
        chk("cfg_no_write_while_tx", 32'(bad), 0);
        chk("cfg_busy_held", 32'(cfg_busy), 1);
        st = 4'b1010;
        wait_stb(2'd0, "cfg");
        chk("cfg_we", 32'(we), 1);
        chk("cfg_dat", dat_o, EXP_CFG);
        @(negedge clk);
        chk("cfg_busy_clear", 32'(cfg_busy), 0);

`ifdef UART_ARB_CTRL_RX_EN
        st      = 4'b0010;
        rx_byte = 8'h5A;
        wait_stb(2'd2, "rx1");
        chk("rx1_bsel", 32'(bsel), 32'h1);
        chk("rx1_we", 32'(we), 0);
        @(negedge clk);
        chk("rx1_valid", 32'(rx_valid), 1);
        chk("rx1_data", 32'(rx_data), 32'h5A);
        rx_byte = 8'h77;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (stb && adr == 2'd2) bad++;
        end
        chk("rx_no_pop_while_full", 32'(bad), 0);
        chk("rx_data_held", 32'(rx_data), 32'h5A);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        wait_stb(2'd2, "rx2");
        @(negedge clk);
        chk("rx2_valid", 32'(rx_valid), 1);
        chk("rx2_data", 32'(rx_data), 32'h77);
        st = 4'b1010;
`endif

        req_valid = 2'b11;
        st        = 4'b1010;
        wait_stb(2'd3, "tx_rst");
        rst_n = 1'b0;
        #1;
        chk("arst_stb", 32'(stb), 0);
        chk("arst_adr", 32'(adr), 0);
        chk("arst_we", 32'(we), 0);
        chk("arst_dat", dat_o, 0);
        chk("arst_ready", 32'(req_ready), 0);
        chk("arst_init_done", 32'(init_done), 0);
        chk("arst_rx_valid", 32'(rx_valid), 0);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_stb(2'd0, "reinit");
        chk("reinit_dat", dat_o, EXP_INIT);
        @(negedge clk);
        chk("reinit_done", 32'(init_done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
